// File: rtl/multicycle_ctrl_fsm_if.sv
// Unified memory port shared by instruction fetch and load/store.
// Uses a request/ready handshake.
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit CPU datapath.
// Sequences the datapath through fetch, decode, execute, memory and writeback, and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [3:0]  OP_RTYPE = 4'd15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic                 alu_cond,
  multicycle_ctrl_fsm_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 is_wwd,
  output logic                 is_halted,
  output logic [CNT_W-1:0]     num_inst
);

  localparam int unsigned OP_W = 4;
  localparam int unsigned FN_W = 6;

  localparam logic [OP_W-1:0] OP_BNE = 4'd0;
  localparam logic [OP_W-1:0] OP_BEQ = 4'd1;
  localparam logic [OP_W-1:0] OP_ADI = 4'd4;
  localparam logic [OP_W-1:0] OP_ORI = 4'd5;
  localparam logic [OP_W-1:0] OP_LHI = 4'd6;
  localparam logic [OP_W-1:0] OP_LWD = 4'd7;
  localparam logic [OP_W-1:0] OP_SWD = 4'd8;
  localparam logic [OP_W-1:0] OP_JMP = 4'd9;

  localparam logic [FN_W-1:0] FN_ALU_LAST = 6'd7;
  localparam logic [FN_W-1:0] FN_WWD      = 6'd28;
  localparam logic [FN_W-1:0] FN_HLT      = 6'd29;

  typedef enum logic [3:0] {
    S_RST,
    S_IF,
    S_ID,
    S_EX_R,
    S_WB_R,
    S_EX_I,
    S_WB_I,
    S_ADDR,
    S_MRD,
    S_WB_M,
    S_MWR,
    S_BR,
    S_JMP,
    S_WWD,
    S_HLT
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       is_wwd;
    logic       is_halted;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  logic   retire;

  // alu_cond qualifies pc_write_cond inside the datapath; the sequencer never needs it.
  logic unused_alu_cond;
  assign unused_alu_cond = alu_cond;

  // Decoded successor of S_ID; S_IF means the instruction is a NOP.
  function automatic state_t id_target(input logic [OP_W-1:0] op, input logic [FN_W-1:0] fn);
    state_t t;
    t = S_IF;
    if (op == OP_RTYPE) begin
      if (fn <= FN_ALU_LAST)  t = S_EX_R;
      else if (fn == FN_WWD)  t = S_WWD;
      else if (fn == FN_HLT)  t = S_HLT;
      else                    t = S_IF;
    end else begin
      case (op)
        OP_ADI, OP_ORI, OP_LHI: t = S_EX_I;
        OP_LWD, OP_SWD:         t = S_ADDR;
        OP_BNE, OP_BEQ:         t = S_BR;
        OP_JMP:                 t = S_JMP;
        default:                t = S_IF;
      endcase
    end
    return t;
  endfunction

  // Control word asserted while sitting in a given state.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_req   = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      S_ID: c.alu_src_b = 2'd2;
      S_EX_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd1;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EX_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = (op == OP_ORI) ? 2'd3 : 2'd2;
        c.alu_op    = 2'd3;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      S_MRD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_WB_M: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_BR: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'd2;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'd1;
      end
      S_JMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      S_WWD:   c.is_wwd    = 1'b1;
      S_HLT:   c.is_halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  // Next state, retire strobe and the control word for the next state
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF:  if (mem.mem_ready) state_d = S_ID;
      S_ID: begin
        state_d = id_target(opcode, func_code);
        retire  = (state_d == S_IF) || (state_d == S_HLT);
      end
      S_EX_R: state_d = S_WB_R;
      S_EX_I: state_d = S_WB_I;
      S_ADDR: state_d = (opcode == OP_LWD) ? S_MRD : S_MWR;
      S_MRD:  if (mem.mem_ready) state_d = S_WB_M;
      S_MWR: begin
        if (mem.mem_ready) begin
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_M, S_BR, S_JMP, S_WWD: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_HLT:   state_d = S_HLT;
      default: state_d = S_RST;
    endcase
    ctrl_d = ctrl_decode(state_d, opcode);
  end

  // Registered control word and retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      num_inst <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (retire) num_inst <= num_inst + CNT_W'(1);
    end
  end

  assign mem.mem_req    = ctrl_q.mem_req;
  assign mem.mem_we     = ctrl_q.mem_we;
  assign mem.i_or_d     = ctrl_q.i_or_d;
  assign ir_write       = ctrl_q.ir_write;
  // PC+1 during fetch is committed only on the completing cycle.
  assign pc_write       = ctrl_q.pc_write | ((state_q == S_IF) & mem.mem_ready);
  assign pc_write_cond  = ctrl_q.pc_write_cond;
  assign pc_source      = ctrl_q.pc_source;
  assign alu_src_a      = ctrl_q.alu_src_a;
  assign alu_src_b      = ctrl_q.alu_src_b;
  assign alu_op         = ctrl_q.alu_op;
  assign reg_dst        = ctrl_q.reg_dst;
  assign mem_to_reg     = ctrl_q.mem_to_reg;
  assign reg_write      = ctrl_q.reg_write;
  assign is_wwd         = ctrl_q.is_wwd;
  assign is_halted      = ctrl_q.is_halted;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm.
// Directed and random instruction streams are checked against a per-instruction phase model.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       is_wwd;
    logic       is_halted;
  } ctl_t;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_ALU_R, P_WB_R, P_ALU_I, P_WB_I, P_ADDR,
                P_LOAD, P_WB_LOAD, P_STORE, P_BRANCH, P_JUMP, P_WWD, P_HALT} phase_e;
  typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_JMP, C_WWD, C_HLT, C_NOP} cls_e;

  logic             clk;
  logic             reset_n;
  logic [3:0]       opcode;
  logic [5:0]       func_code;
  logic             alu_cond;
  logic             ir_write, pc_write, pc_write_cond, alu_src_a;
  logic [1:0]       pc_source, alu_src_b, alu_op;
  logic             reg_dst, mem_to_reg, reg_write, is_wwd, is_halted;
  logic [CNT_W-1:0] num_inst;

  int               checks;
  int               failures;
  logic [CNT_W-1:0] exp_cnt;
  logic             cond_sel;

  multicycle_ctrl_fsm_if mif ();

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .OP_RTYPE(4'd15)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .func_code     (func_code),
    .alu_cond      (alu_cond),
    .mem           (mif.master),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .is_wwd        (is_wwd),
    .is_halted     (is_halted),
    .num_inst      (num_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t observed();
    return {mif.mem_req, mif.mem_we, mif.i_or_d, ir_write, pc_write, pc_write_cond,
            pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
            is_wwd, is_halted};
  endfunction

  // Expected control word for each instruction phase, straight from the control table.
  function automatic ctl_t expect_ctl(input phase_e p, input logic rdy, input logic ori);
    ctl_t c;
    c = '0;
    case (p)
      P_FETCH:   begin c.mem_req = 1; c.ir_write = 1; c.alu_src_b = 2'd1; c.pc_write = rdy; end
      P_DECODE:  c.alu_src_b = 2'd2;
      P_ALU_R:   begin c.alu_src_a = 1; c.alu_op = 2'd1; end
      P_WB_R:    begin c.reg_dst = 1; c.reg_write = 1; end
      P_ALU_I:   begin c.alu_src_a = 1; c.alu_src_b = ori ? 2'd3 : 2'd2; c.alu_op = 2'd3; end
      P_WB_I:    c.reg_write = 1;
      P_ADDR:    begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      P_LOAD:    begin c.mem_req = 1; c.i_or_d = 1; end
      P_WB_LOAD: begin c.mem_to_reg = 1; c.reg_write = 1; end
      P_STORE:   begin c.mem_req = 1; c.mem_we = 1; c.i_or_d = 1; end
      P_BRANCH:  begin c.alu_src_a = 1; c.alu_op = 2'd2; c.pc_write_cond = 1; c.pc_source = 2'd1; end
      P_JUMP:    begin c.pc_write = 1; c.pc_source = 2'd2; end
      P_WWD:     c.is_wwd = 1;
      P_HALT:    c.is_halted = 1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic cls_e classify(input logic [3:0] op, input logic [5:0] fn);
    if (op == 4'd15) begin
      if (fn < 6'd8)        return C_R;
      else if (fn == 6'd28) return C_WWD;
      else if (fn == 6'd29) return C_HLT;
      else                  return C_NOP;
    end
    case (op)
      4'd4, 4'd5, 4'd6: return C_I;
      4'd7:             return C_LD;
      4'd8:             return C_ST;
      4'd0, 4'd1:       return C_BR;
      4'd9:             return C_JMP;
      default:          return C_NOP;
    endcase
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t exp);
    ctl_t got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
    checks++;
    assert (num_inst === exp) else begin
      failures++;
      $error("FAIL %s num_inst observed=%h expected=%h", tag, num_inst, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check just after, then wait for the next falling edge.
  task automatic cyc(input phase_e p, input logic rdy, input logic ori, input string tag);
    mif.mem_ready = rdy;
    alu_cond      = cond_sel;
    #1;
    chk_ctl(tag, expect_ctl(p, rdy, ori));
    @(negedge clk);
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [5:0] fn, input int fw, input int mw);
    cls_e cls;
    opcode    = op;
    func_code = fn;
    cls       = classify(op, fn);
    chk_cnt("num_inst_start", exp_cnt);
    repeat (fw) cyc(P_FETCH, 1'b0, 1'b0, "fetch_wait");
    cyc(P_FETCH, 1'b1, 1'b0, "fetch_done");
    cyc(P_DECODE, 1'($urandom), 1'b0, "decode");
    case (cls)
      C_R:   begin cyc(P_ALU_R, 1'($urandom), 1'b0, "alu_r"); cyc(P_WB_R, 1'($urandom), 1'b0, "wb_r"); end
      C_I:   begin cyc(P_ALU_I, 1'($urandom), op == 4'd5, "alu_i"); cyc(P_WB_I, 1'($urandom), 1'b0, "wb_i"); end
      C_LD: begin
        cyc(P_ADDR, 1'($urandom), 1'b0, "addr_ld");
        repeat (mw) cyc(P_LOAD, 1'b0, 1'b0, "load_wait");
        cyc(P_LOAD, 1'b1, 1'b0, "load_done");
        cyc(P_WB_LOAD, 1'($urandom), 1'b0, "wb_load");
      end
      C_ST: begin
        cyc(P_ADDR, 1'($urandom), 1'b0, "addr_st");
        repeat (mw) cyc(P_STORE, 1'b0, 1'b0, "store_wait");
        cyc(P_STORE, 1'b1, 1'b0, "store_done");
      end
      C_BR:    cyc(P_BRANCH, 1'($urandom), 1'b0, "branch");
      C_JMP:   cyc(P_JUMP, 1'($urandom), 1'b0, "jump");
      C_WWD:   cyc(P_WWD, 1'($urandom), 1'b0, "wwd");
      default: ;
    endcase
    exp_cnt = exp_cnt + CNT_W'(1);
    if (cls == C_HLT) begin
      for (int i = 0; i < 20; i++) begin
        cyc(P_HALT, 1'($urandom), 1'b0, "halted");
        chk_cnt("num_inst_halted", exp_cnt);
      end
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    mif.mem_ready = 1'b0;
    opcode        = 4'd0;
    func_code     = 6'd0;
    alu_cond      = 1'b0;
    @(negedge clk);
    #1;
    chk_ctl("in_reset", '0);
    chk_cnt("in_reset_cnt", '0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = '0;
    cyc(P_IDLE, 1'b1, 1'b0, "post_reset");
  endtask

  initial begin
    logic [3:0] rop;
    logic [5:0] rfn;
    checks   = 0;
    failures = 0;
    cond_sel = 1'b0;
    do_reset();

    do_instr(4'd15, 6'd0, 0, 0);
    chk_cnt("after_add", CNT_W'(1));
    do_instr(4'd15, 6'd3, 3, 0);
    do_instr(4'd7, 6'd0, 0, 2);
    do_instr(4'd8, 6'd0, 1, 1);
    cond_sel = 1'b0;
    do_instr(4'd1, 6'd0, 0, 0);
    cond_sel = 1'b1;
    do_instr(4'd1, 6'd0, 0, 0);
    do_instr(4'd0, 6'd0, 2, 0);
    do_instr(4'd4, 6'd0, 0, 0);
    do_instr(4'd5, 6'd0, 0, 0);
    do_instr(4'd6, 6'd0, 0, 0);
    do_instr(4'd9, 6'd0, 0, 0);
    do_instr(4'd2, 6'd0, 0, 0);
    do_instr(4'd12, 6'd0, 1, 0);
    do_instr(4'd15, 6'd10, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop      = 4'($urandom_range(0, 15));
      rfn      = 6'($urandom_range(0, 63));
      if (rfn == 6'd29) rfn = 6'd28;
      cond_sel = 1'($urandom);
      do_instr(rop, rfn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    do_instr(4'd15, 6'd28, 0, 0);
    do_instr(4'd15, 6'd29, 0, 0);

    do_reset();
    for (int i = 0; i < 255; i++) do_instr(4'd3, 6'd0, 0, 0);
    chk_cnt("pre_wrap", CNT_W'(255));
    do_instr(4'd3, 6'd0, 0, 0);
    chk_cnt("wrap", CNT_W'(0));
    do_instr(4'd15, 6'd1, 0, 0);

    // Reset asserted between clock edges while a store is waiting for memory.
    opcode    = 4'd8;
    func_code = 6'd0;
    chk_cnt("mwr_start", exp_cnt);
    cyc(P_FETCH, 1'b1, 1'b0, "mwr_fetch");
    cyc(P_DECODE, 1'b0, 1'b0, "mwr_decode");
    cyc(P_ADDR, 1'b0, 1'b0, "mwr_addr");
    cyc(P_STORE, 1'b0, 1'b0, "mwr_wait");
    mif.mem_ready = 1'b0;
    #1;
    chk_ctl("mwr_pending", expect_ctl(P_STORE, 1'b0, 1'b0));
    #1;
    reset_n = 1'b0;
    #1;
    chk_ctl("async_reset", '0);
    chk_cnt("async_reset_cnt", '0);
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(P_IDLE, 1'b1, 1'b0, "post_async_reset");
    do_instr(4'd15, 6'd2, 1, 0);
    chk_cnt("recover", CNT_W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
